// File: rtl/game_pkg.sv
// Shared types and constants for the flappy-bird game scheduler.
// The optional difficulty speed-up is enabled with GAME_SPEEDUP_EN.
package game_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StOver = 2'd2
  } game_state_e;

  localparam int unsigned LevelW   = 3;
  localparam logic [LevelW-1:0] LevelMax = 3'd7;

  localparam int unsigned DefTickW      = 16;
  localparam int unsigned DefBasePeriod = 400;
  localparam int unsigned DefMinPeriod  = 100;
  localparam int unsigned DefStep       = 50;

endpackage

// File: rtl/game_if.sv
// Scheduler bus: control inputs from game logic, strobes and status back to the datapath.
interface game_if
  import game_pkg::*;
#(
  parameter int unsigned TICK_W = DefTickW
);
  logic              start;
  logic              lose;
  logic              pass;
  logic              gravity_tick;
  logic              shift_tick;
  logic              spawn;
  logic              freeze;
  logic              clear;
  logic [1:0]        state;
  logic [LevelW-1:0] level;
  logic [TICK_W-1:0] period;

  modport master (
    input  start, lose, pass,
    output gravity_tick, shift_tick, spawn, freeze, clear, state, level, period
  );

  modport slave (
    output start, lose, pass,
    input  gravity_tick, shift_tick, spawn, freeze, clear, state, level, period
  );
endinterface

// File: rtl/tick_divider.sv
// Enable-gated modulo-N counter; wrap_o is high on the enabled cycle that returns it to 0.
module tick_divider #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [Width-1:0] limit_i,
  output logic             wrap_o
);
  logic [Width-1:0] cnt_q, cnt_d;

  // >= keeps the counter bounded even if the limit ever drops below the count
  assign wrap_o = en_i && (cnt_q >= limit_i - Width'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/game_scheduler.sv
// Game FSM (IDLE/RUN/OVER) and gravity/shift/spawn strobe generation.
// Define GAME_SPEEDUP_EN to enable pass-driven levels and period shortening.
module game_scheduler
  import game_pkg::*;
#(
  parameter int unsigned TICK_W           = DefTickW,
  parameter int unsigned BASE_PERIOD      = DefBasePeriod,
  parameter int unsigned MIN_PERIOD       = DefMinPeriod,
  parameter int unsigned STEP             = DefStep,
  parameter int unsigned SHIFT_DIV        = 2,
  parameter int unsigned SPAWN_GAP        = 4,
  parameter int unsigned PASSES_PER_LEVEL = 4
) (
  input logic     clk,
  input logic     reset,
  game_if.master  bus
);
  game_state_e state_q, state_d;
  logic go_idle, tick_en;
  logic tick_wrap, shift_wrap, spawn_wrap;
  logic gravity_q, shift_q, spawn_q, freeze_q, clear_q;
  logic [LevelW-1:0] level_cur;
  logic [TICK_W-1:0] period_cur;

  always_comb begin
    state_d = state_q;
    go_idle = 1'b0;
    unique case (state_q)
      StIdle: if (bus.start) state_d = StRun;
      StRun:  if (bus.lose)  state_d = StOver;
      StOver: if (bus.start) begin
        state_d = StIdle;
        go_idle = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // Counting includes the start edge so the first gravity tick lands one period after start
  assign tick_en = (state_d == StRun);

  tick_divider #(.Width(TICK_W)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (go_idle),
    .en_i    (tick_en),
    .limit_i (period_cur),
    .wrap_o  (tick_wrap)
  );

  tick_divider #(.Width(TICK_W)) u_shift (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (go_idle),
    .en_i    (tick_wrap),
    .limit_i (TICK_W'(SHIFT_DIV)),
    .wrap_o  (shift_wrap)
  );

  tick_divider #(.Width(TICK_W)) u_spawn (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (go_idle),
    .en_i    (shift_wrap),
    .limit_i (TICK_W'(SPAWN_GAP)),
    .wrap_o  (spawn_wrap)
  );

`ifdef GAME_SPEEDUP_EN
  localparam int unsigned ExtW  = TICK_W + 3;
  localparam int unsigned PassW = (PASSES_PER_LEVEL > 1) ? $clog2(PASSES_PER_LEVEL) : 1;

  logic [LevelW-1:0] level_q, level_d;
  logic [PassW-1:0]  pass_cnt_q, pass_cnt_d;
  logic [TICK_W-1:0] period_q, period_d, target;
  logic [ExtW-1:0]   dec;
  logic              pass_en;

  assign pass_en = (state_q == StRun) && !bus.lose && bus.pass;
  assign dec     = ExtW'(level_q) * ExtW'(STEP);

  always_comb begin
    if (dec + ExtW'(MIN_PERIOD) > ExtW'(BASE_PERIOD)) target = TICK_W'(MIN_PERIOD);
    else                                              target = TICK_W'(ExtW'(BASE_PERIOD) - dec);
  end

  always_comb begin
    level_d    = level_q;
    pass_cnt_d = pass_cnt_q;
    period_d   = period_q;
    if (go_idle) begin
      level_d    = '0;
      pass_cnt_d = '0;
      period_d   = TICK_W'(BASE_PERIOD);
    end else begin
      if (pass_en) begin
        if (pass_cnt_q == PassW'(PASSES_PER_LEVEL - 1)) begin
          pass_cnt_d = '0;
          if (level_q != LevelMax) level_d = level_q + 1'b1;
        end else begin
          pass_cnt_d = pass_cnt_q + 1'b1;
        end
      end
      // Target is taken from the pre-pass level so a coincident pass lands one wrap later
      if (tick_wrap) period_d = target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q    <= '0;
      pass_cnt_q <= '0;
      period_q   <= TICK_W'(BASE_PERIOD);
    end else begin
      level_q    <= level_d;
      pass_cnt_q <= pass_cnt_d;
      period_q   <= period_d;
    end
  end

  assign level_cur  = level_q;
  assign period_cur = period_q;
`else
  logic unused_pass;
  assign unused_pass = bus.pass;
  assign level_cur   = '0;
  assign period_cur  = TICK_W'(BASE_PERIOD);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      gravity_q <= 1'b0;
      shift_q   <= 1'b0;
      spawn_q   <= 1'b0;
      freeze_q  <= 1'b1;
      clear_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      gravity_q <= tick_wrap;
      shift_q   <= shift_wrap;
      spawn_q   <= spawn_wrap;
      freeze_q  <= (state_d != StRun);
      clear_q   <= go_idle;
    end
  end

  assign bus.state        = state_q;
  assign bus.gravity_tick = gravity_q;
  assign bus.shift_tick   = shift_q;
  assign bus.spawn        = spawn_q;
  assign bus.freeze       = freeze_q;
  assign bus.clear        = clear_q;
  assign bus.level        = level_cur;
  assign bus.period       = period_cur;
endmodule

// File: tb/tb_game_scheduler.sv
// Directed bench for game_scheduler with small periods; adapts level checks to GAME_SPEEDUP_EN.
// Outputs are read 1 time unit after a posedge, i.e. the value the next edge samples.
module tb_game_scheduler;
  logic clk = 1'b0;
  logic reset;
  int n_cmp = 0;
  int n_err = 0;

  game_if #(.TICK_W(16)) bus ();

  game_scheduler #(
    .TICK_W           (16),
    .BASE_PERIOD      (8),
    .MIN_PERIOD       (4),
    .STEP             (2),
    .SHIFT_DIV        (2),
    .SPAWN_GAP        (3),
    .PASSES_PER_LEVEL (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_pass(input int k);
    bus.pass = 1'b1;
    repeat (k) step();
    bus.pass = 1'b0;
  endtask

  task automatic wait_grav(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.gravity_tick && n < 64);
    check_eq("grav_seen", {31'd0, bus.gravity_tick}, 1);
  endtask

  function automatic logic [31:0] strobes();
    return {28'd0, bus.gravity_tick, bus.shift_tick, bus.spawn, bus.clear};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [3:0] e;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.lose  = 1'b0;
    bus.pass  = 1'b0;
    step();
    step();
    reset = 1'b0;

    // Idle: nothing moves
    for (int i = 0; i < 20; i++) begin
      step();
      check_eq("idle_strobes", strobes(), 0);
    end
    check_eq("idle_state", 32'(bus.state), 0);
    check_eq("idle_freeze", {31'd0, bus.freeze}, 1);
    check_eq("idle_period", 32'(bus.period), 8);
    check_eq("idle_level", 32'(bus.level), 0);

    // Start: gravity every 8, shift every 16, spawn every 48
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check_eq("run_state", 32'(bus.state), 1);
    check_eq("run_freeze", {31'd0, bus.freeze}, 0);
    for (int m = 1; m <= 47; m++) begin
      step();
      e = {(m % 8 == 7), (m % 16 == 15), (m % 48 == 47), 1'b0};
      check_eq("run_strobes", strobes(), {28'd0, e});
    end

`ifdef GAME_SPEEDUP_EN
    pulse_pass(2);
    check_eq("lvl1", 32'(bus.level), 1);
    check_eq("lvl1_period_held", 32'(bus.period), 8);
    wait_grav(n);
    check_eq("lvl1_period", 32'(bus.period), 6);
    wait_grav(n);
    check_eq("lvl1_spacing", 32'(n), 6);
    pulse_pass(4);
    check_eq("lvl3", 32'(bus.level), 3);
    wait_grav(n);
    check_eq("lvl3_period", 32'(bus.period), 4);
    wait_grav(n);
    check_eq("lvl3_spacing", 32'(n), 4);
    pulse_pass(10);
    check_eq("lvl_sat", 32'(bus.level), 7);
    wait_grav(n);
    check_eq("lvl_sat_period", 32'(bus.period), 4);
`else
    pulse_pass(10);
    check_eq("nolvl", 32'(bus.level), 0);
    wait_grav(n);
    check_eq("nolvl_period", 32'(bus.period), 8);
    wait_grav(n);
    check_eq("nolvl_spacing", 32'(n), 8);
`endif

    // Lose: frozen in OVER, level kept
    bus.lose = 1'b1;
    step();
    bus.lose = 1'b0;
    check_eq("over_state", 32'(bus.state), 2);
    check_eq("over_freeze", {31'd0, bus.freeze}, 1);
    for (int i = 0; i < 12; i++) begin
      step();
      check_eq("over_strobes", strobes(), 0);
    end
`ifdef GAME_SPEEDUP_EN
    check_eq("over_level", 32'(bus.level), 7);
`endif

    // OVER -> IDLE with a one-cycle clear
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check_eq("clear_hi", {31'd0, bus.clear}, 1);
    check_eq("clear_state", 32'(bus.state), 0);
    check_eq("clear_level", 32'(bus.level), 0);
    check_eq("clear_period", 32'(bus.period), 8);
    step();
    check_eq("clear_lo", {31'd0, bus.clear}, 0);

    // Second round: first gravity sampled 8 edges after start
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_grav(n);
    check_eq("round2_first", 32'(n), 7);
    pulse_pass(1);
    repeat (6) step();
    // Wrap, pass and lose all land on this edge; only lose may act
    bus.lose = 1'b1;
    bus.pass = 1'b1;
    step();
    bus.lose = 1'b0;
    bus.pass = 1'b0;
    check_eq("lose_grav", {31'd0, bus.gravity_tick}, 0);
    check_eq("lose_state", 32'(bus.state), 2);
    check_eq("lose_freeze", {31'd0, bus.freeze}, 1);
    check_eq("lose_level", 32'(bus.level), 0);

    // Back to RUN, reach level 2, then reset mid-run
    bus.start = 1'b1;
    step();
    check_eq("r3_clear", {31'd0, bus.clear}, 1);
    step();
    bus.start = 1'b0;
    check_eq("r3_state", 32'(bus.state), 1);
    pulse_pass(4);
`ifdef GAME_SPEEDUP_EN
    check_eq("r3_level", 32'(bus.level), 2);
    wait_grav(n);
    check_eq("r3_period", 32'(bus.period), 4);
`else
    check_eq("r3_level", 32'(bus.level), 0);
    wait_grav(n);
    check_eq("r3_period", 32'(bus.period), 8);
`endif
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("rst_state", 32'(bus.state), 0);
    check_eq("rst_level", 32'(bus.level), 0);
    check_eq("rst_period", 32'(bus.period), 8);
    check_eq("rst_clear", {31'd0, bus.clear}, 0);
    check_eq("rst_freeze", {31'd0, bus.freeze}, 1);
    step();
    check_eq("rst_strobes", strobes(), 0);
    check_eq("rst_idle", 32'(bus.state), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
